// File: rtl/ccip_c1_tx_arb_if.sv
// CCI-P C1 write-path signal bundle between N client ports, the arbiter and the upstream channel.
// The master side is the client/upstream environment; the slave side is the arbiter.
interface ccip_c1_tx_arb_if #(
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS-1:0]        port_tx_valid;
  logic [NUM_PORTS-1:0][79:0]  port_tx_hdr;
  logic [NUM_PORTS-1:0][511:0] port_tx_data;
  logic [NUM_PORTS-1:0]        port_almfull;
  logic                        c1TxAlmFull;
  logic                        c1_tx_valid;
  logic [79:0]                 c1_tx_hdr;
  logic [511:0]                c1_tx_data;
  logic                        c1_rx_rspValid;
  logic [27:0]                 c1_rx_hdr;
  logic [NUM_PORTS-1:0]        port_rx_valid;
  logic [27:0]                 port_rx_hdr;
  logic [NUM_PORTS-1:0]        overflow_err;

  modport master (
    output port_tx_valid, port_tx_hdr, port_tx_data, c1TxAlmFull, c1_rx_rspValid, c1_rx_hdr,
    input  port_almfull, c1_tx_valid, c1_tx_hdr, c1_tx_data, port_rx_valid, port_rx_hdr,
           overflow_err
  );

  modport slave (
    input  port_tx_valid, port_tx_hdr, port_tx_data, c1TxAlmFull, c1_rx_rspValid, c1_rx_hdr,
    output port_almfull, c1_tx_valid, c1_tx_hdr, c1_tx_data, port_rx_valid, port_rx_hdr,
           overflow_err
  );
endinterface

// File: rtl/ccip_c1_tx_arb.sv
// Merges NUM_PORTS client C1 write streams onto one C1 Tx channel with packet-locked round-robin,
// tagging mdata with the source port and steering C1 responses back by that tag.
module ccip_c1_tx_arb #(
  parameter int NUM_PORTS       = 4,
  parameter int FIFO_DEPTH      = 16,
  parameter int PORT_ALM_THRESH = 4
) (
  input logic             pClk,
  input logic             SoftReset,
  ccip_c1_tx_arb_if.slave bus
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 80 + 512;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALM_LEVEL  = CW'(FIFO_DEPTH - PORT_ALM_THRESH);
  localparam logic [3:0] REQ_WRFENCE = 4'h4;
  localparam logic [3:0] REQ_INTR    = 4'h6;

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  logic [EW-1:0]        r_mem [NUM_PORTS][FIFO_DEPTH];
  logic [CW-1:0]        r_wptr [NUM_PORTS];
  logic [CW-1:0]        r_rptr [NUM_PORTS];
  logic [CW-1:0]        w_cnt [NUM_PORTS];
  logic [CW-1:0]        w_cnt_nxt [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_empty, w_full, w_push_ok, w_pop;
  logic [NUM_PORTS-1:0] r_almfull, r_ovf;

  state_t               r_state, w_state_nxt;
  logic [PW-1:0]        r_lock_port, w_lock_port_nxt;
  logic [PW-1:0]        r_rr_ptr, w_rr_ptr_nxt;
  logic [1:0]           r_beats_left, w_beats_left_nxt;
  logic [PW-1:0]        w_scan, w_sel_port, w_pop_port;
  logic                 w_sel_found, w_pop_vld;
  logic [EW-1:0]        w_head;
  logic [2:0]           w_beats;
  logic [79:0]          w_issue_hdr;

  logic                 r_tx_vld_p1;
  logic [79:0]          r_tx_hdr_p1;
  logic [511:0]         r_tx_data_p1;
  logic [NUM_PORTS-1:0] w_rx_vld, r_rx_vld_p1;
  logic [27:0]          w_rx_hdr, r_rx_hdr_p1;

  // WRFENCE and INTR are always single-beat; writes carry their length in cl_len.
  function automatic logic [2:0] f_pkt_beats(input logic [79:0] hdr);
    logic [2:0] n;
    if (hdr[67:64] == REQ_WRFENCE || hdr[67:64] == REQ_INTR) begin
      n = 3'd1;
    end else begin
      case (hdr[69:68])
        2'b00:   n = 3'd1;
        2'b01:   n = 3'd2;
        default: n = 3'd4;
      endcase
    end
    return n;
  endfunction

  function automatic logic [PW-1:0] f_next_port(input logic [PW-1:0] p);
    return (int'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
  endfunction

  // Stage p0: per-port request FIFOs
  always_comb begin : fifo_status
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_cnt[p]   = r_wptr[p] - r_rptr[p];
      w_empty[p] = (w_cnt[p] == '0);
      w_full[p]  = (w_cnt[p] == FULL_LEVEL);
    end
  end

  always_comb begin : fifo_update
    w_pop     = '0;
    w_push_ok = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_pop[p]     = w_pop_vld && (w_pop_port == PW'(p));
      // A full FIFO still accepts a push in the cycle it is being popped.
      w_push_ok[p] = bus.port_tx_valid[p] && (!w_full[p] || w_pop[p]);
      w_cnt_nxt[p] = w_cnt[p] + CW'(w_push_ok[p]) - CW'(w_pop[p]);
    end
  end

  always_ff @(posedge pClk or posedge SoftReset) begin
    if (SoftReset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_wptr[p] <= '0;
        r_rptr[p] <= '0;
      end
      r_almfull <= '0;
      r_ovf     <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_push_ok[p]) r_wptr[p] <= r_wptr[p] + 1'b1;
        if (w_pop[p])     r_rptr[p] <= r_rptr[p] + 1'b1;
        r_almfull[p] <= (w_cnt_nxt[p] >= ALM_LEVEL);
        if (bus.port_tx_valid[p] && !w_push_ok[p]) r_ovf[p] <= 1'b1;
      end
    end
  end

  always_ff @(posedge pClk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_push_ok[p]) r_mem[p][r_wptr[p][AW-1:0]] <= {bus.port_tx_hdr[p], bus.port_tx_data[p]};
    end
  end

  // Arbiter FSM: state register
  always_ff @(posedge pClk or posedge SoftReset) begin
    if (SoftReset) begin
      r_state      <= ST_IDLE;
      r_lock_port  <= '0;
      r_beats_left <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_lock_port  <= w_lock_port_nxt;
      r_beats_left <= w_beats_left_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
    end
  end

  // Arbiter FSM: output decode (which FIFO pops this cycle)
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_port  = r_rr_ptr;
    w_scan      = r_rr_ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_scan = PW'((int'(r_rr_ptr) + i) % NUM_PORTS);
      if (!w_sel_found && !w_empty[w_scan]) begin
        w_sel_found = 1'b1;
        w_sel_port  = w_scan;
      end
    end
    w_pop_vld  = 1'b0;
    w_pop_port = w_sel_port;
    case (r_state)
      ST_IDLE: w_pop_vld = w_sel_found && !bus.c1TxAlmFull;
      ST_LOCK: begin
        // Continuation beats ignore upstream almost-full and wait for the client if needed.
        w_pop_port = r_lock_port;
        w_pop_vld  = !w_empty[r_lock_port];
      end
      default: w_pop_vld = 1'b0;
    endcase
  end

  assign w_head  = r_mem[w_pop_port][r_rptr[w_pop_port][AW-1:0]];
  assign w_beats = f_pkt_beats(w_head[EW-1 -: 80]);

  // Arbiter FSM: next state
  always_comb begin
    w_state_nxt      = r_state;
    w_lock_port_nxt  = r_lock_port;
    w_beats_left_nxt = r_beats_left;
    w_rr_ptr_nxt     = r_rr_ptr;
    if (w_pop_vld) begin
      case (r_state)
        ST_IDLE: begin
          if (w_beats == 3'd1) begin
            w_rr_ptr_nxt = f_next_port(w_pop_port);
          end else begin
            w_state_nxt      = ST_LOCK;
            w_lock_port_nxt  = w_pop_port;
            w_beats_left_nxt = 2'(w_beats - 3'd1);
          end
        end
        ST_LOCK: begin
          w_beats_left_nxt = r_beats_left - 2'd1;
          if (r_beats_left == 2'd1) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = f_next_port(r_lock_port);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_issue_hdr            = w_head[EW-1 -: 80];
    w_issue_hdr[15 -: PW]  = w_pop_port;
  end

  always_comb begin
    w_rx_vld = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_rx_vld[p] = bus.c1_rx_rspValid && (bus.c1_rx_hdr[15 -: PW] == PW'(p));
    end
    w_rx_hdr           = bus.c1_rx_hdr;
    w_rx_hdr[15 -: PW] = '0;
  end

  // Stage p1: registered Tx and Rx outputs
  always_ff @(posedge pClk or posedge SoftReset) begin
    if (SoftReset) begin
      r_tx_vld_p1 <= 1'b0;
      r_rx_vld_p1 <= '0;
    end else begin
      r_tx_vld_p1 <= w_pop_vld;
      r_rx_vld_p1 <= w_rx_vld;
    end
  end

  always_ff @(posedge pClk) begin
    if (w_pop_vld) begin
      r_tx_hdr_p1  <= w_issue_hdr;
      r_tx_data_p1 <= w_head[511:0];
    end
    r_rx_hdr_p1 <= w_rx_hdr;
  end

  assign bus.c1_tx_valid   = r_tx_vld_p1;
  assign bus.c1_tx_hdr     = r_tx_hdr_p1;
  assign bus.c1_tx_data    = r_tx_data_p1;
  assign bus.port_rx_valid = r_rx_vld_p1;
  assign bus.port_rx_hdr   = r_rx_hdr_p1;
  assign bus.port_almfull  = r_almfull;
  assign bus.overflow_err  = r_ovf;
endmodule

// File: tb/tb_ccip_c1_tx_arb.sv
// Randomized bench for ccip_c1_tx_arb against a queue-based reference of the arbitration rules.
module tb_ccip_c1_tx_arb;
  localparam int NP    = 4;
  localparam int DEPTH = 16;
  localparam int THR   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ccip_c1_tx_arb_if #(.NUM_PORTS(NP)) bus ();

  ccip_c1_tx_arb #(.NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .PORT_ALM_THRESH(THR)) dut (
    .pClk(clk), .SoftReset(rst), .bus(bus)
  );

  typedef struct packed { logic [79:0] hdr; logic [511:0] data; } beat_t;

  beat_t mq [NP][$];    // reference FIFO contents
  beat_t pend [NP][$];  // client beats not yet pushed
  bit             m_lock;
  int             m_lport, m_left, m_rr;
  logic [NP-1:0]  m_ovf;
  logic           exp_vld;
  logic [591:0]   exp_beat;
  logic [NP-1:0]  exp_alm, exp_rxv;
  logic [27:0]    exp_rxhdr;
  int             obs_log [$];
  int             n_chk, n_err;

  task automatic chk(input string tag, input logic [591:0] obs, input logic [591:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nbeats(input logic [79:0] h);
    if (h[67:64] == 4'h4 || h[67:64] == 4'h6) return 1;
    if (h[69:68] == 2'b00) return 1;
    if (h[69:68] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic m_reset();
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      pend[p].delete();
    end
    m_lock = 0; m_lport = 0; m_left = 0; m_rr = 0; m_ovf = '0;
  endtask

  // kind: 0 one line, 1 two lines, 2 four lines, 3 fence, 4 interrupt; md < 0 picks a random mdata
  task automatic gen_pkt(input int p, input int kind, input int md);
    logic [79:0] h;
    beat_t x;
    int n;
    h = '0;
    h[57:16] = 42'({$urandom(), $urandom()});
    h[15:0]  = (md < 0) ? 16'($urandom_range(0, 16'h3FFF)) : 16'(md);
    h[73:72] = 2'($urandom_range(0, 3));
    h[67:64] = 4'($urandom_range(0, 2));
    case (kind)
      1: h[69:68] = 2'b01;
      2: h[69:68] = 2'b11;
      3: h[67:64] = 4'h4;
      4: h[67:64] = 4'h6;
      default: h[69:68] = 2'b00;
    endcase
    n = nbeats(h);
    for (int b = 0; b < n; b++) begin
      x.hdr = h;
      x.hdr[71] = (b == 0);
      x.hdr[17:16] = 2'(b);
      x.data = rnd512();
      pend[p].push_back(x);
    end
  endtask

  task automatic feed(input int pct, input bit ign_alm);
    beat_t x;
    for (int p = 0; p < NP; p++) begin
      bus.port_tx_valid[p] = 1'b0;
      if (pend[p].size() > 0 && (ign_alm || mq[p].size() < DEPTH - THR) &&
          $urandom_range(1, 100) <= pct) begin
        x = pend[p].pop_front();
        bus.port_tx_valid[p] = 1'b1;
        bus.port_tx_hdr[p]   = x.hdr;
        bus.port_tx_data[p]  = x.data;
      end
    end
  endtask

  // Predict the edge from the current inputs, advance one clock and compare.
  task automatic cycle();
    int pp, n;
    beat_t b;
    pp = -1;
    if (m_lock) begin
      if (mq[m_lport].size() > 0) pp = m_lport;
    end else if (!bus.c1TxAlmFull) begin
      for (int i = 0; i < NP; i++)
        if (pp < 0 && mq[(m_rr + i) % NP].size() > 0) pp = (m_rr + i) % NP;
    end
    exp_vld = (pp >= 0);
    if (pp >= 0) begin
      b = mq[pp].pop_front();
      b.hdr[15:14] = 2'(pp);
      exp_beat = b;
      if (m_lock) begin
        m_left--;
        if (m_left == 0) begin m_lock = 0; m_rr = (pp + 1) % NP; end
      end else begin
        n = nbeats(b.hdr);
        if (n > 1) begin m_lock = 1; m_lport = pp; m_left = n - 1; end
        else m_rr = (pp + 1) % NP;
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (bus.port_tx_valid[p]) begin
        if (mq[p].size() < DEPTH) begin
          b.hdr = bus.port_tx_hdr[p];
          b.data = bus.port_tx_data[p];
          mq[p].push_back(b);
        end else m_ovf[p] = 1'b1;
      end
      exp_alm[p] = (mq[p].size() >= DEPTH - THR);
    end
    exp_rxv = bus.c1_rx_rspValid ? (NP'(1) << bus.c1_rx_hdr[15:14]) : '0;
    exp_rxhdr = bus.c1_rx_hdr;
    exp_rxhdr[15:14] = 2'b00;
    @(posedge clk);
    #1;
    chk("tx_valid", bus.c1_tx_valid, exp_vld);
    if (exp_vld) chk("tx_beat", {bus.c1_tx_hdr, bus.c1_tx_data}, exp_beat);
    if (bus.c1_tx_valid) obs_log.push_back(int'(bus.c1_tx_hdr[15:14]));
    chk("almfull", bus.port_almfull, exp_alm);
    chk("overflow", bus.overflow_err, m_ovf);
    chk("rx_valid", bus.port_rx_valid, exp_rxv);
    chk("rx_onehot", ($countones(bus.port_rx_valid) <= 1), 1);
    if (exp_rxv != '0) chk("rx_hdr", bus.port_rx_hdr, exp_rxhdr);
  endtask

  task automatic step(input int pct, input bit ign_alm);
    feed(pct, ign_alm);
    cycle();
  endtask

  task automatic idle_inputs();
    bus.port_tx_valid  = '0;
    bus.port_tx_hdr    = '0;
    bus.port_tx_data   = '0;
    bus.c1TxAlmFull    = 1'b0;
    bus.c1_rx_rspValid = 1'b0;
    bus.c1_rx_hdr      = '0;
  endtask

  int exp_seq [9] = '{1, 1, 1, 1, 2, 3, 3, 3, 3};
  int cnt0;
  bit pend_left;

  initial begin
    n_chk = 0; n_err = 0;
    m_reset();
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txv", bus.c1_tx_valid, 0);
    chk("rst_rxv", bus.port_rx_valid, 0);
    chk("rst_alm", bus.port_almfull, 0);
    chk("rst_ovf", bus.overflow_err, 0);
    rst = 1'b0;
    repeat (2) step(100, 0);

    // single line on port 0: visible two clocks after the push
    gen_pkt(0, 0, 16'h0012);
    step(100, 0);
    chk("lat_t1", bus.c1_tx_valid, 0);
    step(100, 0);
    chk("lat_t2", bus.c1_tx_valid, 1);
    chk("lat_mdata", bus.c1_tx_hdr[15:0], 16'h0012);
    repeat (2) step(100, 0);

    // two 4-line packets and a single line competing
    obs_log.delete();
    gen_pkt(1, 2, -1); gen_pkt(3, 2, -1); gen_pkt(2, 0, -1);
    repeat (14) step(100, 0);
    chk("seq_len", obs_log.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < obs_log.size()) chk("seq_port", obs_log[i], exp_seq[i]);

    // upstream almost-full raised mid packet
    obs_log.delete();
    gen_pkt(0, 2, -1); gen_pkt(1, 0, -1);
    cnt0 = 0;
    for (int k = 0; k < 20 && cnt0 < 2; k++) begin
      step(100, 0);
      cnt0 = 0;
      foreach (obs_log[i]) if (obs_log[i] == 0) cnt0++;
    end
    chk("alm_setup", cnt0, 2);
    bus.c1TxAlmFull = 1'b1;
    obs_log.delete();
    repeat (6) step(100, 0);
    chk("alm_cont_beats", obs_log.size(), 2);
    bus.c1TxAlmFull = 1'b0;
    obs_log.delete();
    repeat (4) step(100, 0);
    chk("alm_release", obs_log.size(), 1);

    // fill port 0 past full while upstream is blocked
    bus.c1TxAlmFull = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      gen_pkt(0, 0, -1);
      step(100, 1);
      if (k == 11) chk("alm_after_11", bus.port_almfull[0], 0);
      if (k == 12) chk("alm_after_12", bus.port_almfull[0], 1);
      if (k == 16) chk("ovf_after_16", bus.overflow_err[0], 0);
      if (k == 17) chk("ovf_after_17", bus.overflow_err[0], 1);
    end
    bus.c1TxAlmFull = 1'b0;
    obs_log.delete();
    repeat (24) step(100, 0);
    chk("drain_count", obs_log.size(), 16);
    chk("ovf_sticky", bus.overflow_err[0], 1);

    // response steering
    bus.c1_rx_rspValid = 1'b1;
    bus.c1_rx_hdr = {12'($urandom()), 16'h8005};
    step(100, 0);
    chk("rsp_vld", bus.port_rx_valid, 4'b0100);
    chk("rsp_mdata", bus.port_rx_hdr[15:0], 16'h0005);
    bus.c1_rx_rspValid = 1'b0;
    step(100, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++)
        if (pend[p].size() == 0 && $urandom_range(0, 3) == 0) gen_pkt(p, $urandom_range(0, 4), -1);
      bus.c1TxAlmFull    = ($urandom_range(0, 4) == 0);
      bus.c1_rx_rspValid = 1'($urandom_range(0, 1));
      bus.c1_rx_hdr      = 28'($urandom());
      step(60, 0);
    end
    bus.c1TxAlmFull = 1'b0;
    bus.c1_rx_rspValid = 1'b0;
    pend_left = 1;
    for (int k = 0; k < 300 && pend_left; k++) begin
      step(100, 0);
      pend_left = 0;
      for (int p = 0; p < NP; p++) if (pend[p].size() > 0 || mq[p].size() > 0) pend_left = 1;
    end
    repeat (4) step(100, 0);
    chk("drained", pend_left, 0);

    // reset while a 2-line packet waits for its second beat
    gen_pkt(2, 1, -1);
    void'(pend[2].pop_back());
    bus.c1_rx_rspValid = 1'b1;
    bus.c1_rx_hdr = 28'h0004000;
    obs_log.delete();
    for (int k = 0; k < 10 && obs_log.size() == 0; k++) step(100, 0);
    chk("rst_setup", obs_log.size(), 1);
    chk("rst_setup_rx", bus.port_rx_valid, 4'b0010);
    bus.c1_rx_rspValid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_txv", bus.c1_tx_valid, 0);
    chk("midrst_rxv", bus.port_rx_valid, 0);
    chk("midrst_ovf", bus.overflow_err, 0);
    chk("midrst_alm", bus.port_almfull, 0);
    idle_inputs();
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs_log.delete();
    repeat (10) step(100, 0);
    chk("post_rst_idle", obs_log.size(), 0);
    gen_pkt(3, 0, -1);
    repeat (4) step(100, 0);
    chk("post_rst_fresh", obs_log.size(), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
